// File: rtl/seven_segment_scanner.sv
// Scan controller for a common-anode multi-digit seven-segment display.
// One digit per refresh slot, tear-free frame updates, zero blanking.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   value, load     hex value and its capture strobe (nibble 0 = right)
//   suppress_zeros  level, enables leading-zero blanking
//   digit           nibble of the selected digit for the segment decoder
//   digit_blank     1 = decoder must drive segments off this slot
//   anodes          active-low digit enables, at most one low
//   frame_done      one-cycle pulse after the last slot of a frame
module seven_segment_scanner #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  suppress_zeros,
  output logic [3:0]            digit,
  output logic                  digit_blank,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int VW = 4 * DIGITS;

  localparam logic [PW-1:0] PS_LAST =
    PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] ON_START =
    PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(DIGITS - 1);

  logic [PW-1:0] prescaler;
  logic [IW-1:0] index;
  logic [VW-1:0] shadow;
  logic [VW-1:0] pending;
  logic          pending_valid;
  logic          sup_q;

  logic          tc;
  logic          wrap;
  logic [PW-1:0] ps_nx;
  logic [IW-1:0] idx_nx;
  logic [VW-1:0] shadow_nx;
  logic          sup_nx;
  logic [DIGITS-1:0] anodes_nx;
  logic [3:0]    digit_nx;
  logic          hi_nz;
  logic          blank_nx;

  assign tc   = (prescaler == PS_LAST);
  assign wrap = tc && (index == IDX_LAST);

  // Next-slot state; outputs are computed from it so that
  // anodes/digit/digit_blank move on the same edge as index.
  always_comb begin
    ps_nx  = tc ? '0 : prescaler + PW'(1);
    idx_nx = index;
    if (tc) begin
      idx_nx = wrap ? '0 : index + IW'(1);
    end
  end

  // Shadow only changes at a frame wrap; a load on the wrap
  // cycle bypasses pending so it is never lost or delayed.
  always_comb begin
    shadow_nx = shadow;
    if (wrap) begin
      if (load) begin
        shadow_nx = value;
      end else if (pending_valid) begin
        shadow_nx = pending;
      end
    end
  end

  assign sup_nx = tc ? suppress_zeros : sup_q;

  always_comb begin
    anodes_nx = '1;
    if (ps_nx >= ON_START) begin
      anodes_nx[idx_nx] = 1'b0;
    end
  end

  assign digit_nx = shadow_nx[{idx_nx, 2'b00} +: 4];

  // Any nonzero nibble at or above the selected digit keeps
  // the digit lit.
  always_comb begin
    hi_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(idx_nx) && shadow_nx[4*i +: 4] != 4'h0) begin
        hi_nz = 1'b1;
      end
    end
  end

  assign blank_nx = sup_nx && (idx_nx != '0) && !hi_nz;

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler     <= '0;
      index         <= '0;
      shadow        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      sup_q         <= 1'b0;
      anodes        <= '1;
      digit         <= 4'h0;
      digit_blank   <= 1'b1;
      frame_done    <= 1'b0;
    end else begin
      prescaler <= ps_nx;
      index     <= idx_nx;
      shadow    <= shadow_nx;
      sup_q     <= sup_nx;
      if (load) begin
        pending <= value;
      end
      if (wrap) begin
        pending_valid <= 1'b0;
      end else if (load) begin
        pending_valid <= 1'b1;
      end
      anodes      <= anodes_nx;
      digit       <= digit_nx;
      digit_blank <= blank_nx;
      frame_done  <= wrap;
    end
  end

endmodule
